// File: rtl/trigger_servo_pkg.sv
// Shared definitions for the trigger-rate servo: FSM state codes, field widths
// and the threshold saturation helper.
package trigger_servo_pkg;

    localparam int THRESH_BITS = 18;
    localparam int COUNT_BITS  = 32;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE  = 4'd0;
    localparam state_t S_REQ   = 4'd1;
    localparam state_t S_WAIT  = 4'd2;
    localparam state_t S_MUL0  = 4'd3;
    localparam state_t S_MUL1  = 4'd4;
    localparam state_t S_SAT   = 4'd5;
    localparam state_t S_STAGE = 4'd6;
    localparam state_t S_CE    = 4'd7;
    localparam state_t S_NEXT  = 4'd8;
    localparam state_t S_UPD   = 4'd9;

    // Clamp a wide signed threshold candidate into [lo, 2^THRESH_BITS-1].
    function automatic logic [THRESH_BITS-1:0] sat_thresh(
        input logic signed [67:0]            v,
        input logic        [THRESH_BITS-1:0] lo
    );
        logic signed [67:0] lo_s;
        logic signed [67:0] hi_s;
        lo_s = $signed({{(68-THRESH_BITS){1'b0}}, lo});
        hi_s = $signed({{(68-THRESH_BITS){1'b0}}, {THRESH_BITS{1'b1}}});
        if (v < lo_s)
            return lo;
        else if (v > hi_s)
            return {THRESH_BITS{1'b1}};
        else
            return v[THRESH_BITS-1:0];
    endfunction

endpackage

// File: rtl/trigger_rate_servo_pmul.sv
// Shared proportional-correction datapath: err register, registered signed
// 33x32 multiply, then arithmetic shift and saturation. Honours TRIGGER_SERVO_DEADBAND_EN.
module servo_pmul
    import trigger_servo_pkg::*;
#(
    parameter int          NFRAC_KP   = 10,
    parameter int unsigned THRESH_MIN = 0
)(
    input  logic                   clk_i,
    input  logic                   err_en_i,
    input  logic                   mul_en_i,
    input  logic                   sat_en_i,
    input  logic [COUNT_BITS-1:0]  count_i,
    input  logic [31:0]            target_i,
    input  logic [31:0]            kp_i,
    input  logic [THRESH_BITS-1:0] thresh_i,
`ifdef TRIGGER_SERVO_DEADBAND_EN
    input  logic [31:0]            deadband_i,
`endif
    output logic [THRESH_BITS-1:0] new_thresh_o,
    output logic                   skip_o
);

    localparam logic [THRESH_BITS-1:0] TMIN = THRESH_BITS'(THRESH_MIN);

    logic signed [32:0]            err_p0_q;
    logic signed [65:0]            prod_p1_q;
    logic        [THRESH_BITS-1:0] new_p2_q;
    logic                          skip_p2_q;

    logic signed [65:0] delta;
    logic signed [67:0] sum;
    logic               in_band;

    assign delta = prod_p1_q >>> NFRAC_KP;
    assign sum   = $signed({{2{delta[65]}}, delta})
                 + $signed({{(68-THRESH_BITS){1'b0}}, thresh_i});

`ifdef TRIGGER_SERVO_DEADBAND_EN
    logic [32:0] err_mag;
    assign err_mag = err_p0_q[32] ? $unsigned(-err_p0_q) : $unsigned(err_p0_q);
    assign in_band = (err_mag <= {1'b0, deadband_i});
`else
    assign in_band = 1'b0;
`endif

    // p0: error, p1: product, p2: saturated threshold; each loads on its FSM step
    always_ff @(posedge clk_i) begin
        if (err_en_i)
            err_p0_q <= $signed({1'b0, count_i}) - $signed({1'b0, target_i});
        if (mul_en_i)
            prod_p1_q <= err_p0_q * $signed({1'b0, kp_i});
        if (sat_en_i) begin
            new_p2_q  <= in_band ? thresh_i : sat_thresh(sum, TMIN);
            skip_p2_q <= in_band;
        end
    end

    assign new_thresh_o = new_p2_q;
    assign skip_o       = skip_p2_q;

endmodule

// File: rtl/trigger_rate_servo.sv
// Closed-loop proportional servo for L1 beam trigger thresholds (wishbone domain).
// Optional deadband port/behaviour enabled by TRIGGER_SERVO_DEADBAND_EN.
module trigger_rate_servo
    import trigger_servo_pkg::*;
#(
    parameter int          NBEAMS             = 2,
    parameter int unsigned STARTING_THRESHOLD = 4000,
    parameter int unsigned THRESH_MIN         = 0,
    parameter int          NFRAC_KP           = 10,
    parameter int unsigned WAIT_TIMEOUT       = 2**30
)(
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          enable_i,
    input  logic [31:0]                   target_i,
    input  logic [31:0]                   kp_i,
    output logic                          req_count_o,
    input  logic                          count_done_i,
    input  logic [NBEAMS*COUNT_BITS-1:0]  count_i,
    output logic [THRESH_BITS-1:0]        thresh_o,
    output logic [NBEAMS-1:0]             thresh_ce_o,
    output logic                          update_o,
    output logic [NBEAMS*THRESH_BITS-1:0] thresh_rd_o,
    output logic                          busy_o,
    output logic                          timeout_o
`ifdef TRIGGER_SERVO_DEADBAND_EN
    ,
    input  logic [31:0]                   deadband_i
`endif
);

    localparam int BW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
    localparam int TW = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [TW-1:0]          TIMER_LAST = TW'(WAIT_TIMEOUT - 1);
    localparam logic [BW-1:0]          LAST_BEAM  = BW'(NBEAMS - 1);
    localparam logic [THRESH_BITS-1:0] THRESH_RST = THRESH_BITS'(STARTING_THRESHOLD);

    state_t                 state_q, state_d;
    logic [BW-1:0]          beam_q, beam_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   en_q;
    logic                   timeout_q, timeout_d;
    logic                   req_q, upd_q, busy_q;
    logic [NBEAMS-1:0]      ce_q;
    logic [THRESH_BITS-1:0] thresh_o_q;
    logic [THRESH_BITS-1:0] thresh_q [NBEAMS];

    logic [NBEAMS*COUNT_BITS-1:0] count_q;
    logic [COUNT_BITS-1:0]        count_sel;
    logic [THRESH_BITS-1:0]       thresh_sel;
    logic [THRESH_BITS-1:0]       new_thresh;
    logic                         skip;

    always_comb begin
        count_sel  = '0;
        thresh_sel = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            if (beam_q == BW'(b)) begin
                count_sel  = count_q[b*COUNT_BITS +: COUNT_BITS];
                thresh_sel = thresh_q[b];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        beam_d    = beam_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        if (enable_i && !en_q)
            timeout_d = 1'b0;
        case (state_q)
            S_IDLE:  if (enable_i) state_d = S_REQ;
            S_REQ: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (count_done_i) begin
                    beam_d  = '0;
                    state_d = S_MUL0;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_MUL0:  state_d = S_MUL1;
            S_MUL1:  state_d = S_SAT;
            S_SAT:   state_d = S_STAGE;
            S_STAGE: state_d = S_CE;
            S_CE:    state_d = S_NEXT;
            S_NEXT: begin
                if (beam_q == LAST_BEAM) begin
                    state_d = S_UPD;
                end else begin
                    beam_d  = beam_q + BW'(1);
                    state_d = S_MUL0;
                end
            end
            // Enable is only consulted here, so an iteration always commits whole
            S_UPD:   state_d = enable_i ? S_REQ : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counts are pure data: captured only on an accepted window completion
    always_ff @(posedge wb_clk_i) begin
        if (state_q == S_WAIT && count_done_i)
            count_q <= count_i;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            beam_q     <= '0;
            timer_q    <= '0;
            en_q       <= 1'b0;
            timeout_q  <= 1'b0;
            req_q      <= 1'b0;
            upd_q      <= 1'b0;
            busy_q     <= 1'b0;
            ce_q       <= '0;
            thresh_o_q <= '0;
            for (int b = 0; b < NBEAMS; b++)
                thresh_q[b] <= THRESH_RST;
        end else begin
            state_q   <= state_d;
            beam_q    <= beam_d;
            timer_q   <= timer_d;
            en_q      <= enable_i;
            timeout_q <= timeout_d;
            // Pulse outputs are decoded from the next state so they align with it
            req_q     <= (state_d == S_REQ);
            upd_q     <= (state_d == S_UPD);
            busy_q    <= (state_d != S_IDLE);
            ce_q      <= '0;
            if (state_d == S_CE && !skip)
                ce_q[beam_q] <= 1'b1;
            if (state_q == S_STAGE) begin
                thresh_o_q       <= new_thresh;
                thresh_q[beam_q] <= new_thresh;
            end
        end
    end

    servo_pmul #(
        .NFRAC_KP   (NFRAC_KP),
        .THRESH_MIN (THRESH_MIN)
    ) u_pmul (
        .clk_i        (wb_clk_i),
        .err_en_i     (state_q == S_MUL0),
        .mul_en_i     (state_q == S_MUL1),
        .sat_en_i     (state_q == S_SAT),
        .count_i      (count_sel),
        .target_i     (target_i),
        .kp_i         (kp_i),
        .thresh_i     (thresh_sel),
`ifdef TRIGGER_SERVO_DEADBAND_EN
        .deadband_i   (deadband_i),
`endif
        .new_thresh_o (new_thresh),
        .skip_o       (skip)
    );

    for (genvar g = 0; g < NBEAMS; g++) begin : g_rd
        assign thresh_rd_o[g*THRESH_BITS +: THRESH_BITS] = thresh_q[g];
    end

    assign req_count_o = req_q;
    assign update_o    = upd_q;
    assign thresh_ce_o = ce_q;
    assign thresh_o    = thresh_o_q;
    assign busy_o      = busy_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_trigger_rate_servo.sv
// Directed self-checking bench for trigger_rate_servo (NBEAMS=2, WAIT_TIMEOUT=64).
module tb_trigger_rate_servo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] target = 32'd100;
    logic [31:0] kp = 32'h400;
    logic        req;
    logic        done = 1'b0;
    logic [63:0] count = '0;
    logic [17:0] thresh;
    logic [1:0]  ce;
    logic        upd;
    logic [35:0] rd;
    logic        busy;
    logic        tmo;
`ifdef TRIGGER_SERVO_DEADBAND_EN
    logic [31:0] deadband = '0;
`endif

    logic [17:0] rd0, rd1;
    assign rd0 = rd[17:0];
    assign rd1 = rd[35:18];

    int checks = 0;
    int errors = 0;
    int ce0_at, ce1_at, upd_at, ce_pulses;
    logic [17:0] ce0_val, ce1_val;

    always #5 clk = ~clk;

    trigger_rate_servo #(.WAIT_TIMEOUT(64)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .enable_i     (enable),
        .target_i     (target),
        .kp_i         (kp),
        .req_count_o  (req),
        .count_done_i (done),
        .count_i      (count),
        .thresh_o     (thresh),
        .thresh_ce_o  (ce),
        .update_o     (upd),
        .thresh_rd_o  (rd),
        .busy_o       (busy),
        .timeout_o    (tmo)
`ifdef TRIGGER_SERVO_DEADBAND_EN
        ,
        .deadband_i   (deadband)
`endif
    );

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        done = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Waits for req_count_o, then one more cycle so the FSM sits in WAIT.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (req) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // Pulses count_done_i and records CE/update timing relative to it.
    task automatic run_iter(input logic [31:0] c0, input logic [31:0] c1, input int drop_at);
        ce0_at = -1; ce1_at = -1; upd_at = -1; ce_pulses = 0;
        ce0_val = '0; ce1_val = '0;
        count = {c1, c0};
        done = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) done = 1'b0;
            if (n == drop_at) enable = 1'b0;
            if (ce != 2'b00) ce_pulses++;
            if (ce == 2'b01) begin ce0_at = n; ce0_val = thresh; end
            if (ce == 2'b10) begin ce1_at = n; ce1_val = thresh; end
            if (upd) begin
                upd_at = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rd !== {18'd4000, 18'd4000}) begin errors++; $display("FAIL reset_rd got %h want %h", rd, {18'd4000, 18'd4000}); end
        checks++; if (thresh !== 18'd0) begin errors++; $display("FAIL reset_thresh got %0d want 0", thresh); end
        checks++; if ({req, ce, upd, busy, tmo} !== 6'b0) begin errors++; $display("FAIL reset_ctrl got %b want 000000", {req, ce, upd, busy, tmo}); end
    endtask

    task automatic test_basic();
        bit ok;
        do_reset();
        target = 32'd100; kp = 32'h400; enable = 1'b1;
        wait_req(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_req got %0d want 1", ok); end
        run_iter(32'd150, 32'd100, 0);
        checks++; if (rd0 !== 18'd4050) begin errors++; $display("FAIL basic_rd0 got %0d want 4050", rd0); end
        checks++; if (rd1 !== 18'd4000) begin errors++; $display("FAIL basic_rd1 got %0d want 4000", rd1); end
        checks++; if (ce0_at !== 5) begin errors++; $display("FAIL basic_ce0_at got %0d want 5", ce0_at); end
        checks++; if (ce1_at !== 11) begin errors++; $display("FAIL basic_ce1_at got %0d want 11", ce1_at); end
        checks++; if (ce0_val !== 18'd4050) begin errors++; $display("FAIL basic_ce0_val got %0d want 4050", ce0_val); end
        checks++; if (ce1_val !== 18'd4000) begin errors++; $display("FAIL basic_ce1_val got %0d want 4000", ce1_val); end
        checks++; if (upd_at !== 13) begin errors++; $display("FAIL basic_upd_at got %0d want 13", upd_at); end
        checks++; if (ce_pulses !== 2) begin errors++; $display("FAIL basic_ce_count got %0d want 2", ce_pulses); end
    endtask

    task automatic test_half_gain();
        bit ok;
        do_reset();
        target = 32'd100; kp = 32'h200; enable = 1'b1;
        wait_req(ok);
        run_iter(32'd101, 32'd99, 0);
        checks++; if (rd0 !== 18'd4000) begin errors++; $display("FAIL half_rd0 got %0d want 4000", rd0); end
        checks++; if (rd1 !== 18'd3999) begin errors++; $display("FAIL half_rd1 got %0d want 3999", rd1); end
        checks++; if (upd_at !== 13) begin errors++; $display("FAIL half_upd_at got %0d want 13", upd_at); end
    endtask

    task automatic test_kp_zero();
        bit ok;
        do_reset();
        target = 32'd100; kp = 32'h0; enable = 1'b1;
        wait_req(ok);
        run_iter(32'd500, 32'd0, 0);
        checks++; if (rd !== {18'd4000, 18'd4000}) begin errors++; $display("FAIL kp0_rd got %h want %h", rd, {18'd4000, 18'd4000}); end
        checks++; if (ce_pulses !== 2) begin errors++; $display("FAIL kp0_ce_count got %0d want 2", ce_pulses); end
        checks++; if (upd_at !== 13) begin errors++; $display("FAIL kp0_upd_at got %0d want 13", upd_at); end
    endtask

    task automatic test_saturation();
        bit ok;
        do_reset();
        target = 32'd100; kp = 32'h400; enable = 1'b1;
        wait_req(ok);
        run_iter(32'd258200, 32'd100, 0);
        checks++; if (rd0 !== 18'd262100) begin errors++; $display("FAIL sat_ramp_rd0 got %0d want 262100", rd0); end
        target = 32'd4050;
        wait_req(ok);
        run_iter(32'd4050, 32'd100, 0);
        checks++; if (rd1 !== 18'd50) begin errors++; $display("FAIL sat_ramp_rd1 got %0d want 50", rd1); end
        target = 32'd100;
        wait_req(ok);
        run_iter(32'd1000, 32'd0, 0);
        checks++; if (rd0 !== 18'd262143) begin errors++; $display("FAIL sat_high got %0d want 262143", rd0); end
        checks++; if (rd1 !== 18'd0) begin errors++; $display("FAIL sat_low got %0d want 0", rd1); end
        checks++; if (ce1_val !== 18'd0) begin errors++; $display("FAIL sat_low_staged got %0d want 0", ce1_val); end
    endtask

    task automatic test_timeout();
        bit ok;
        int tmo_at;
        int pulses;
        do_reset();
        target = 32'd100; kp = 32'h400; enable = 1'b1;
        wait_req(ok);
        tmo_at = -1; pulses = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (ce != 2'b00 || upd) pulses++;
            if (tmo) begin
                tmo_at = n;
                break;
            end
        end
        enable = 1'b0;
        checks++; if (tmo_at !== 64) begin errors++; $display("FAIL tmo_at got %0d want 64", tmo_at); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL tmo_pulses got %0d want 0", pulses); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle got busy %0d want 0", busy); end
        // A completion arriving while idle must be ignored
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_stray_done got busy %0d want 0", busy); end
        checks++; if (tmo !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %0d want 1", tmo); end
        checks++; if (rd !== {18'd4000, 18'd4000}) begin errors++; $display("FAIL tmo_rd got %h want %h", rd, {18'd4000, 18'd4000}); end
        enable = 1'b1;
        @(posedge clk); #1;
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL tmo_clear got %0d want 0", tmo); end
        do_reset();
    endtask

    task automatic test_enable_drop();
        bit ok;
        int reqs;
        do_reset();
        target = 32'd100; kp = 32'h400; enable = 1'b1;
        wait_req(ok);
        run_iter(32'd150, 32'd100, 2);
        checks++; if (ce_pulses !== 2) begin errors++; $display("FAIL drop_ce_count got %0d want 2", ce_pulses); end
        checks++; if (upd_at !== 13) begin errors++; $display("FAIL drop_upd_at got %0d want 13", upd_at); end
        checks++; if (rd !== {18'd4000, 18'd4050}) begin errors++; $display("FAIL drop_rd got %h want %h", rd, {18'd4000, 18'd4050}); end
        reqs = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (req) reqs++;
        end
        checks++; if (reqs !== 0) begin errors++; $display("FAIL drop_no_req got %0d want 0", reqs); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle got busy %0d want 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int seen;
        do_reset();
        target = 32'd100; kp = 32'h400; enable = 1'b1;
        wait_req(ok);
        count = {32'd100, 32'd150};
        done = 1'b1;
        seen = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 1) done = 1'b0;
            if (ce != 2'b00) begin
                seen = n;
                break;
            end
        end
        checks++; if (seen !== 5) begin errors++; $display("FAIL rstmid_ce_at got %0d want 5", seen); end
        rst = 1'b1;
        #1;
        checks++; if ({req, ce, upd, busy, tmo} !== 6'b0) begin errors++; $display("FAIL rstmid_ctrl got %b want 000000", {req, ce, upd, busy, tmo}); end
        checks++; if (thresh !== 18'd0) begin errors++; $display("FAIL rstmid_thresh got %0d want 0", thresh); end
        checks++; if (rd !== {18'd4000, 18'd4000}) begin errors++; $display("FAIL rstmid_rd got %h want %h", rd, {18'd4000, 18'd4000}); end
        enable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

`ifdef TRIGGER_SERVO_DEADBAND_EN
    task automatic test_deadband();
        bit ok;
        do_reset();
        target = 32'd100; kp = 32'h400; deadband = 32'd10; enable = 1'b1;
        wait_req(ok);
        run_iter(32'd105, 32'd120, 0);
        checks++; if (ce_pulses !== 1) begin errors++; $display("FAIL db_ce_count got %0d want 1", ce_pulses); end
        checks++; if (ce1_at !== 11) begin errors++; $display("FAIL db_ce1_at got %0d want 11", ce1_at); end
        checks++; if (rd !== {18'd4020, 18'd4000}) begin errors++; $display("FAIL db_rd got %h want %h", rd, {18'd4020, 18'd4000}); end
        checks++; if (upd_at !== 13) begin errors++; $display("FAIL db_upd_at got %0d want 13", upd_at); end
        deadband = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_half_gain();
        test_kp_zero();
        test_saturation();
        test_timeout();
        test_enable_drop();
        test_reset_mid();
`ifdef TRIGGER_SERVO_DEADBAND_EN
        test_deadband();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
